// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - decode->execute issue/stall controller with busy scoreboard
module hazard_scoreboard_ctrl #(
  parameter int NREGS   = 32,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rnum1,
  input  logic             id_use1,
  input  logic [AW-1:0]    id_rnum2,
  input  logic             id_use2,
  input  logic [AW-1:0]    id_wnum,
  input  logic             id_is_write_reg,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic             is_nop,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_wnum,
  output logic [NREGS-1:0] busy_vec,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [NREGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LATENCY-1:0] st_vld_q;
  logic [LATENCY-1:0] st_wr_q;
  logic [AW-1:0]      st_wnum_q [LATENCY];
  logic               hazard;

  // No bypass network: any pending write to a source or the destination blocks issue.
  always_comb begin
    hazard = (id_use1 & busy_q[id_rnum1])
           | (id_use2 & busy_q[id_rnum2])
           | (id_is_write_reg & busy_q[id_wnum]);
    stall  = id_valid & hazard & ~flush;
    issue  = id_valid & ~hazard & ~flush;
    is_nop = ~issue;
  end

  assign wb_valid  = st_vld_q[LATENCY-1] & st_wr_q[LATENCY-1];
  assign wb_wnum   = st_wnum_q[LATENCY-1];
  assign busy_vec  = busy_q;
  assign stall_cnt = cnt_q;

  // Clear of the retiring write first, then the issuing set, so set wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_wnum] = 1'b0;
    end
    if (issue && id_is_write_reg) begin
      busy_d[id_wnum] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      st_vld_q <= '0;
      st_wr_q  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        st_wnum_q[k] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      st_vld_q[0]  <= issue;
      st_wr_q[0]   <= issue & id_is_write_reg & (id_wnum != '0);
      st_wnum_q[0] <= issue ? id_wnum : '0;
      for (int k = 1; k < LATENCY; k++) begin
        st_vld_q[k]  <= flush ? 1'b0 : st_vld_q[k-1];
        st_wr_q[k]   <= flush ? 1'b0 : st_wr_q[k-1];
        st_wnum_q[k] <= flush ? '0 : st_wnum_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb/tb_hazard_scoreboard_ctrl.sv - directed bench for hazard_scoreboard_ctrl (LATENCY=3)
module tb_hazard_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use1, id_use2, id_is_write_reg, flush;
  logic [4:0]  id_rnum1, id_rnum2, id_wnum;
  logic        stall, issue, is_nop, wb_valid;
  logic [4:0]  wb_wnum;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;
  logic        s_stall, s_issue, s_is_nop, s_wb_valid;
  logic [4:0]  s_wb_wnum;
  logic [31:0] s_busy_vec;
  logic [1:0]  s_stall_cnt;
  int          n_pass = 0;
  int          n_total = 0;

  hazard_scoreboard_ctrl #(.NREGS(32), .LATENCY(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rnum1(id_rnum1), .id_use1(id_use1),
    .id_rnum2(id_rnum2), .id_use2(id_use2), .id_wnum(id_wnum),
    .id_is_write_reg(id_is_write_reg), .flush(flush), .stall(stall), .issue(issue),
    .is_nop(is_nop), .wb_valid(wb_valid), .wb_wnum(wb_wnum), .busy_vec(busy_vec),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard_ctrl #(.NREGS(32), .LATENCY(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rnum1(id_rnum1), .id_use1(id_use1),
    .id_rnum2(id_rnum2), .id_use2(id_use2), .id_wnum(id_wnum),
    .id_is_write_reg(id_is_write_reg), .flush(flush), .stall(s_stall), .issue(s_issue),
    .is_nop(s_is_nop), .wb_valid(s_wb_valid), .wb_wnum(s_wb_wnum), .busy_vec(s_busy_vec),
    .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] w, input logic wr);
    id_valid = v; id_rnum1 = r1; id_use1 = u1; id_rnum2 = r2; id_use2 = u2;
    id_wnum = w; id_is_write_reg = wr;
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_wnum", 32'(wb_wnum), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b1;

    // RAW on r5: three stall cycles, writeback in the third
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    chk("raw_issue_w", 32'(issue), 32'd1);
    tick();
    chk("raw_busy5", busy_vec, 32'h20);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("raw_stall1", 32'(stall), 32'd1);
    chk("raw_nop1", 32'(is_nop), 32'd1);
    chk("raw_wb1", 32'(wb_valid), 32'd0);
    tick();
    chk("raw_stall2", 32'(stall), 32'd1);
    chk("raw_wb2", 32'(wb_valid), 32'd0);
    tick();
    chk("raw_stall3", 32'(stall), 32'd1);
    chk("raw_wb3", 32'(wb_valid), 32'd1);
    chk("raw_wnum3", 32'(wb_wnum), 32'd5);
    chk("raw_busy_in_wb", busy_vec, 32'h20);
    tick();
    chk("raw_release_stall", 32'(stall), 32'd0);
    chk("raw_release_issue", 32'(issue), 32'd1);
    chk("raw_cnt", 32'(stall_cnt), 32'd3);
    chk("raw_busy_clr", busy_vec, 32'h0);
    tick();

    // Independent writes r1,r2,r3 back-to-back
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1);
      chk("ind_issue", 32'(issue), 32'd1);
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("ind_busy", busy_vec, 32'h0E);
    chk("ind_wb1", 32'(wb_valid), 32'd1);
    chk("ind_wnum1", 32'(wb_wnum), 32'd1);
    tick();
    chk("ind_wnum2", 32'(wb_wnum), 32'd2);
    chk("ind_busy2", busy_vec, 32'h0C);
    tick();
    chk("ind_wnum3", 32'(wb_wnum), 32'd3);
    chk("ind_busy3", busy_vec, 32'h08);
    tick();
    chk("ind_wb_done", 32'(wb_valid), 32'd0);
    chk("ind_busy_done", busy_vec, 32'h0);

    // r0 write/read and unused operand of a busy register
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    chk("r0_w_issue", 32'(issue), 32'd1);
    tick();
    chk("r0_busy", busy_vec, 32'h0);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    chk("r0_r_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    chk("r0_wb_never", 32'(wb_valid), 32'd0);
    tick();
    drive(1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    chk("unused_stall", 32'(stall), 32'd0);
    chk("unused_issue", 32'(issue), 32'd1);
    drive(1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    chk("used_stall", 32'(stall), 32'd1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); tick(); tick();
    chk("r7_drained", busy_vec, 32'h0);

    // WAW on r9 resolved by flush
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    chk("waw_busy9", busy_vec, 32'h200);
    chk("waw_stall", 32'(stall), 32'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_no_stall", 32'(stall), 32'd0);
    chk("flush_no_issue", 32'(issue), 32'd0);
    chk("flush_nop", 32'(is_nop), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", busy_vec, 32'h0);
    chk("flush_then_issue", 32'(issue), 32'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("flush_reissue_busy", busy_vec, 32'h200);
    chk("flush_old_cancel", 32'(wb_valid), 32'd0);
    tick(); tick();
    chk("flush_new_wb", 32'(wb_valid), 32'd1);
    chk("flush_new_wnum", 32'(wb_wnum), 32'd9);
    chk("waw_cnt", 32'(stall_cnt), 32'd4);
    tick();

    // Asynchronous reset mid-stream with r5 busy
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    chk("mid_busy5", busy_vec, 32'h20);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_busy", busy_vec, 32'h0);
    chk("async_wb", 32'(wb_valid), 32'd0);
    chk("async_cnt", 32'(stall_cnt), 32'd0);
    chk("async_cnt_sat", 32'(s_stall_cnt), 32'd0);
    tick();
    chk("held_busy", busy_vec, 32'h0);
    rst = 1'b1;

    // Two chained RAWs: six stall cycles, 2-bit counter saturates at 3
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    chk("sat_first_issue", 32'(issue), 32'd1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("sat_cnt_a", 32'(stall_cnt), 32'(i));
      chk("sat_cnt_a2", 32'(s_stall_cnt), 32'(i));
    end
    chk("sat_chain_issue", 32'(issue), 32'd1);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 4; i <= 6; i++) begin
      tick();
      chk("sat_cnt_b", 32'(stall_cnt), 32'(i));
      chk("sat_cnt_b2", 32'(s_stall_cnt), 32'd3);
    end
    chk("sat_final_issue", 32'(issue), 32'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("sat_hold", 32'(s_stall_cnt), 32'd3);
    chk("cnt_hold", 32'(stall_cnt), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
